// File: rtl/uart_buffered_tx_if.sv
// Byte-queue and serial-line signals of the buffered UART transmitter.
// The master side writes bytes and watches the flags; the slave side is the transmitter.
interface uart_buffered_tx_if;
    logic [7:0] Tx_Data;
    logic       Tx_Send;
    logic       Tx_Full;
    logic       Tx_Empty;
    logic       Tx_Busy;
    logic       Tx_Overflow;
    logic       Tx;

    modport master (
        output Tx_Data, Tx_Send,
        input  Tx_Full, Tx_Empty, Tx_Busy, Tx_Overflow, Tx
    );

    modport slave (
        input  Tx_Data, Tx_Send,
        output Tx_Full, Tx_Empty, Tx_Busy, Tx_Overflow, Tx
    );
endinterface

// File: rtl/uart_buffered_tx.sv
// 8-N-1 UART transmitter fed by a byte FIFO; frames go out back-to-back while bytes are queued.
// Tx and Tx_Busy are registered from the current state, so the line lags the FSM by one clock.
//
//  state   | meaning
//  S_IDLE  | line high, waiting for a queued byte
//  S_START | start bit (low)
//  S_DATA  | eight data bits, LSB first
//  S_STOP  | stop bit (high), then pop next byte or go idle
module uart_buffered_tx #(
    parameter int unsigned          CNT_WIDTH  = 14,
    parameter logic [CNT_WIDTH-1:0] BAUD_DIV   = 14'd9999,
    parameter int unsigned          DEPTH_LOG2 = 4
) (
    input  logic              Clk_100M,
    input  logic              Reset,
    uart_buffered_tx_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [2:0]              bit_q, bit_d;
    logic [7:0]              shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    full_q, full_d;
    logic                    empty_q, empty_d;
    logic                    ovf_q, ovf_d;
    logic [7:0]              mem_q [DEPTH];

    logic push;
    logic pop;
    logic have_data;
    logic baud_done;

    // A write is judged against the registered full flag, so a same-cycle pop cannot rescue it.
    assign push      = bus.Tx_Send && !full_q;
    assign have_data = (count_q != '0);
    assign baud_done = (cnt_q == BAUD_DIV);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (have_data) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    cnt_d = '0;
                    if (have_data) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_q != S_IDLE) || have_data;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
        ovf_d   = bus.Tx_Send && full_q;
    end

    always_ff @(posedge Clk_100M) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge Clk_100M) begin
        if (Reset && push) begin
            mem_q[wr_ptr_q] <= bus.Tx_Data;
        end
    end

    assign bus.Tx          = tx_q;
    assign bus.Tx_Busy     = busy_q;
    assign bus.Tx_Full     = full_q;
    assign bus.Tx_Empty    = empty_q;
    assign bus.Tx_Overflow = ovf_q;

endmodule

// File: tb/tb_uart_buffered_tx.sv
// Bench for uart_buffered_tx with a short bit period: queued bytes are checked against a
// line-decoding monitor that pops expected bytes from a scoreboard queue.
module tb_uart_buffered_tx;
    localparam int BD = 4;

    logic clk = 1'b0;
    logic rst_b;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ovf_seen = 0;
    int   frames = 0;

    logic [7:0] exp_q[$];
    int         fall_q[$];

    uart_buffered_tx_if bus();

    uart_buffered_tx #(
        .CNT_WIDTH (14),
        .BAUD_DIV  (14'd3),
        .DEPTH_LOG2(4)
    ) dut (
        .Clk_100M(clk),
        .Reset   (rst_b),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Line monitor: behaves as an ideal receiver sampling each bit in its middle.
    bit         mon_on = 1'b0;
    int         mon_cnt = 0;
    int         mon_bi = 0;
    logic [7:0] mon_byte = 8'h00;
    always @(negedge clk) begin
        if (bus.Tx_Overflow === 1'b1) ovf_seen++;
        if (rst_b !== 1'b1) begin
            mon_on = 1'b0;
        end else if (!mon_on) begin
            if (bus.Tx === 1'b0) begin
                mon_on  = 1'b1;
                mon_cnt = 0;
                fall_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % BD == BD / 2) begin
                mon_bi = mon_cnt / BD;
                if (mon_bi == 0) begin
                    check("start bit", {31'd0, bus.Tx}, 32'd0);
                end else if (mon_bi <= 8) begin
                    mon_byte[mon_bi-1] = bus.Tx;
                end else begin
                    check("stop bit", {31'd0, bus.Tx}, 32'd1);
                    frames++;
                    mon_on = 1'b0;
                    if (exp_q.size() == 0)
                        check("unexpected frame", {24'd0, mon_byte}, 32'hFFFF_FFFF);
                    else
                        check("frame data", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit accepted);
        bus.Tx_Data = b;
        bus.Tx_Send = 1'b1;
        if (accepted) exp_q.push_back(b);
        step(1);
        bus.Tx_Send = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while ((exp_q.size() != 0 || bus.Tx_Busy !== 1'b0) && n < max) begin
            step(1);
            n++;
        end
        check(name, {31'd0, n >= max}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got cycle %0d expected finish", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int         gap;
        int         lows;
        int         fr0;
        logic [7:0] b;
        logic [7:0] a3;

        bus.Tx_Data = 8'h00;
        bus.Tx_Send = 1'b0;
        rst_b       = 1'b0;
        step(3);
        check("reset tx", {31'd0, bus.Tx}, 32'd1);
        check("reset empty", {31'd0, bus.Tx_Empty}, 32'd1);
        check("reset busy", {31'd0, bus.Tx_Busy}, 32'd0);
        check("reset full", {31'd0, bus.Tx_Full}, 32'd0);
        check("reset overflow", {31'd0, bus.Tx_Overflow}, 32'd0);
        rst_b = 1'b1;
        step(2);
        check("idle tx", {31'd0, bus.Tx}, 32'd1);

        // Single 0xA3 frame, checked clock by clock against the ideal waveform.
        a3 = 8'hA3;
        send(a3, 1'b1);
        check("latency edge0 tx", {31'd0, bus.Tx}, 32'd1);
        step(1);
        check("latency edge1 tx", {31'd0, bus.Tx}, 32'd1);
        check("busy after write", {31'd0, bus.Tx_Busy}, 32'd1);
        for (int k = 0; k < 10 * BD; k++) begin
            logic exp_bit;
            int   p;
            step(1);
            p = k / BD;
            if (p == 0)      exp_bit = 1'b0;
            else if (p <= 8) exp_bit = a3[p-1];
            else             exp_bit = 1'b1;
            check("a3 waveform", {31'd0, bus.Tx}, {31'd0, exp_bit});
            check("a3 busy", {31'd0, bus.Tx_Busy}, 32'd1);
        end
        step(1);
        check("a3 busy end", {31'd0, bus.Tx_Busy}, 32'd0);
        check("a3 tx end", {31'd0, bus.Tx}, 32'd1);
        wait_drain("a3 drain", 50);

        // Random bytes with random gaps, never enough to fill the queue.
        ovf_seen = 0;
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom_range(0, 255));
            send(b, 1'b1);
            gap = $urandom_range(0, 3);
            step(gap);
        end
        wait_drain("random drain", 12 * 10 * BD + 200);
        check("random no overflow", ovf_seen, 32'd0);

        // Fill while a priming frame is on the line, overflow once, then hit a full write
        // on the exact pop edge (40 clocks after the first pop).
        ovf_seen = 0;
        fall_q.delete();
        send(8'hC5, 1'b1);
        step(2);
        for (int i = 0; i <= 16; i++) begin
            bus.Tx_Data = 8'(i);
            bus.Tx_Send = 1'b1;
            if (i < 16) exp_q.push_back(8'(i));
            step(1);
        end
        bus.Tx_Send = 1'b0;
        check("burst overflow pulse", {31'd0, bus.Tx_Overflow}, 32'd1);
        check("burst full", {31'd0, bus.Tx_Full}, 32'd1);
        step(1);
        check("overflow one cycle", {31'd0, bus.Tx_Overflow}, 32'd0);
        check("still full", {31'd0, bus.Tx_Full}, 32'd1);
        step(20);
        send(8'hEE, 1'b0);
        check("pop-edge write overflow", {31'd0, bus.Tx_Overflow}, 32'd1);
        check("pop-edge full cleared", {31'd0, bus.Tx_Full}, 32'd0);
        check("pop-edge not empty", {31'd0, bus.Tx_Empty}, 32'd0);
        wait_drain("burst drain", 2000);
        check("overflow pulses", ovf_seen, 32'd2);
        check("burst frame count", fall_q.size(), 32'd17);
        for (int i = 1; i < fall_q.size(); i++)
            check("back-to-back gap", fall_q[i] - fall_q[i-1], 32'(10 * BD));

        // Reset in the middle of a 0x55 data phase with three bytes queued.
        send(8'h55, 1'b1);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        step(16);
        rst_b = 1'b0;
        step(1);
        check("midreset tx", {31'd0, bus.Tx}, 32'd1);
        check("midreset empty", {31'd0, bus.Tx_Empty}, 32'd1);
        check("midreset busy", {31'd0, bus.Tx_Busy}, 32'd0);
        check("midreset full", {31'd0, bus.Tx_Full}, 32'd0);
        rst_b = 1'b1;
        exp_q.delete();
        fr0  = frames;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (bus.Tx !== 1'b1) lows++;
        end
        check("post-reset line quiet", lows, 32'd0);
        check("post-reset no frames", frames - fr0, 32'd0);

        // Loopback-style receive of 'r'.
        fr0 = frames;
        send(8'h72, 1'b1);
        wait_drain("r drain", 100);
        check("r single frame", frames - fr0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
